queue_event_driver: RTL and testbench

//  Produces the UP/DOWN event pulses for the 3-bit queue occupancy counter.
//  - Conditions two raw sensors: customer arrival and teller service-complete.
//  - Serialises the resulting events and respects the counter's EF/FF flags.
//  - Publishes a wait-time estimate derived from the counter output CO.
//  - Sits between the sensor pads and the occupancy counter.

---
 rtl/sbqm_pkg.sv | 20 ++
 rtl/sbqm_debounce.sv | 46 ++++
 rtl/queue_event_driver.sv | 174 +++++++++++++++++
 tb/tb_queue_event_driver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbqm_pkg.sv
// Shared definitions for the queue occupancy slice (event driver and counter).
// Holds the driver FSM encoding, queue depth and counter width.
package sbqm_pkg;

  localparam int QMAX = 7;
  localparam int CO_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_UP = 2'd1,
    ISSUE_DN = 2'd2,
    SETTLE_W = 2'd3
  } qstate_t;

  // Largest wait estimate the WT register has to represent.
  function automatic int wait_max(input int svc_time);
    return QMAX * svc_time;
  endfunction

endpackage

// File: rtl/sbqm_debounce.sv
// Sensor conditioning: 2-flop synchroniser, debounce counter and a one-cycle
// pulse on the rising edge of the accepted level.
module sbqm_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic CLK,
  input  logic MR,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             rise_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run count.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEB_CYC - 1)) begin
        level_reg <= sync2_reg;
        rise_reg  <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/queue_event_driver.sv
// Turns conditioned arrival/service sensor edges into serialised UP/DOWN
// pulses for the occupancy counter, honouring its EF/FF flags.
module queue_event_driver
  import sbqm_pkg::*;
#(
  parameter int DEB_CYC  = 16,
  parameter int SETTLE   = 2,
  parameter int SVC_TIME = 3,
  parameter int WT_W     = 5
) (
  input  logic            CLK,
  input  logic            MR,
  input  logic            ARR_IN,
  input  logic            SRV_IN,
  input  logic [CO_W-1:0] CO,
  input  logic            EF,
  input  logic            FF,
  output logic            UP,
  output logic            DOWN,
  output logic            REJ,
  output logic            ERR,
  output logic [WT_W-1:0] WT,
  output logic            BUSY
);

  localparam int SC_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  generate
    if (wait_max(SVC_TIME) >= (1 << WT_W)) begin : g_bad_wt_w
      $error("WT_W too narrow for QMAX*SVC_TIME");
    end
    if (SETTLE < 1) begin : g_bad_settle
      $error("SETTLE must be at least 1");
    end
  endgenerate

  // Index 0 = arrival, index 1 = service.
  logic [1:0] raw_vec;
  logic [1:0] rise_vec;

  assign raw_vec = {SRV_IN, ARR_IN};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
      sbqm_debounce #(
        .DEB_CYC (DEB_CYC)
      ) u_deb (
        .CLK  (CLK),
        .MR   (MR),
        .raw  (raw_vec[gi]),
        .rise (rise_vec[gi])
      );
    end
  endgenerate

  qstate_t          state_reg;
  logic [SC_W-1:0]  settle_cnt_reg;
  logic             arr_p_reg;
  logic             srv_p_reg;
  logic             up_reg;
  logic             down_reg;
  logic             rej_reg;
  logic             err_reg;
  logic             busy_reg;
  logic [WT_W-1:0]  wt_reg;

  logic arr_clr;
  logic srv_clr;

  // A pending event is consumed when issued or when dropped against a flag.
  always_comb begin
    arr_clr = 1'b0;
    srv_clr = 1'b0;
    case (state_reg)
      ISSUE_UP: arr_clr = 1'b1;
      ISSUE_DN: srv_clr = 1'b1;
      IDLE: begin
        srv_clr = srv_p_reg & EF;
        arr_clr = ~srv_p_reg & arr_p_reg & FF;
      end
      default: begin
        arr_clr = 1'b0;
        srv_clr = 1'b0;
      end
    endcase
  end

  // A fresh edge wins over a same-cycle clear so it is never lost.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      arr_p_reg <= 1'b0;
      srv_p_reg <= 1'b0;
    end else begin
      arr_p_reg <= (arr_p_reg & ~arr_clr) | rise_vec[0];
      srv_p_reg <= (srv_p_reg & ~srv_clr) | rise_vec[1];
    end
  end

  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      up_reg         <= 1'b0;
      down_reg       <= 1'b0;
      rej_reg        <= 1'b0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      up_reg   <= 1'b0;
      down_reg <= 1'b0;
      rej_reg  <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Service has priority so a simultaneous pair drains before it fills.
          if (srv_p_reg) begin
            if (!EF) begin
              state_reg <= ISSUE_DN;
              busy_reg  <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
          end else if (arr_p_reg) begin
            if (!FF) begin
              state_reg <= ISSUE_UP;
              busy_reg  <= 1'b1;
            end else begin
              rej_reg <= 1'b1;
            end
          end
        end
        ISSUE_UP: begin
          up_reg         <= 1'b1;
          settle_cnt_reg <= '0;
          state_reg      <= SETTLE_W;
        end
        ISSUE_DN: begin
          down_reg       <= 1'b1;
          settle_cnt_reg <= '0;
          state_reg      <= SETTLE_W;
        end
        SETTLE_W: begin
          // Flags lag the counter here, so they are deliberately ignored.
          if (settle_cnt_reg == SC_W'(SETTLE - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      wt_reg <= '0;
    end else begin
      wt_reg <= WT_W'(CO) * WT_W'(SVC_TIME);
    end
  end

  assign UP   = up_reg;
  assign DOWN = down_reg;
  assign REJ  = rej_reg;
  assign ERR  = err_reg;
  assign BUSY = busy_reg;
  assign WT   = wt_reg;

endmodule

// File: tb/tb_queue_event_driver.sv
// Self-checking bench for queue_event_driver with an attached model counter
// and a queue-occupancy reference that predicts every pulse.
module tb_queue_event_driver;

  localparam int DEB_CYC  = 16;
  localparam int SETTLE   = 2;
  localparam int SVC_TIME = 3;
  localparam int WT_W     = 5;

  logic            CLK = 1'b0;
  logic            MR = 1'b1;
  logic            ARR_IN = 1'b0;
  logic            SRV_IN = 1'b0;
  logic [2:0]      CO;
  logic            EF;
  logic            FF;
  logic            UP;
  logic            DOWN;
  logic            REJ;
  logic            ERR;
  logic [WT_W-1:0] WT;
  logic            BUSY;

  int checks = 0;
  int failures = 0;

  queue_event_driver #(
    .DEB_CYC (DEB_CYC),
    .SETTLE  (SETTLE),
    .SVC_TIME(SVC_TIME),
    .WT_W    (WT_W)
  ) dut (
    .CLK   (CLK),
    .MR    (MR),
    .ARR_IN(ARR_IN),
    .SRV_IN(SRV_IN),
    .CO    (CO),
    .EF    (EF),
    .FF    (FF),
    .UP    (UP),
    .DOWN  (DOWN),
    .REJ   (REJ),
    .ERR   (ERR),
    .WT    (WT),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  // Occupancy counter model with a load port for setting up scenarios.
  logic [2:0] co_m;
  logic       co_ld = 1'b0;
  logic [2:0] co_ld_val = 3'd0;

  always @(posedge CLK or posedge MR) begin
    if (MR) co_m <= 3'd0;
    else if (co_ld) co_m <= co_ld_val;
    else if (UP && !DOWN && co_m != 3'd7) co_m <= co_m + 3'd1;
    else if (DOWN && !UP && co_m != 3'd0) co_m <= co_m - 3'd1;
  end

  assign CO = co_m;
  assign EF = (co_m == 3'd0);
  assign FF = (co_m == 3'd7);

  // Pulse monitor sampled on the falling edge.
  int cyc = 0;
  int up_cnt = 0, dn_cnt = 0, rej_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int last_up = -1, last_dn = -1, last_pulse = -1;
  int sep_viol = 0, both_viol = 0;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (UP) begin up_cnt = up_cnt + 1; last_up = cyc; end
    if (DOWN) begin dn_cnt = dn_cnt + 1; last_dn = cyc; end
    if (REJ) rej_cnt = rej_cnt + 1;
    if (ERR) err_cnt = err_cnt + 1;
    if (BUSY) busy_cnt = busy_cnt + 1;
    if (UP && DOWN) both_viol = both_viol + 1;
    if (UP || DOWN) begin
      if (last_pulse >= 0 && (cyc - last_pulse) < SETTLE + 1) sep_viol = sep_viol + 1;
      last_pulse = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input bit is_srv, input int hi, input int lo);
    @(negedge CLK);
    if (is_srv) SRV_IN = 1'b1; else ARR_IN = 1'b1;
    repeat (hi) @(negedge CLK);
    SRV_IN = 1'b0;
    ARR_IN = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic load_co(input logic [2:0] v);
    @(negedge CLK);
    co_ld = 1'b1;
    co_ld_val = v;
    @(negedge CLK);
    co_ld = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset;
    MR = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (UP !== 1'b0) begin failures++; $display("FAIL reset_up: got %0b want 0", UP); end
    checks++; if (DOWN !== 1'b0) begin failures++; $display("FAIL reset_down: got %0b want 0", DOWN); end
    checks++; if (REJ !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL reset_rej_err: got %0b%0b want 00", REJ, ERR); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", BUSY); end
    checks++; if (WT !== '0) begin failures++; $display("FAIL reset_wt: got %0d want 0", WT); end
    MR = 1'b0;
    repeat (3) @(negedge CLK);
    $display("reset: done");
  endtask

  task automatic test_reset_mid_issue;
    int u0;
    bit seen;
    seen = 1'b0;
    @(negedge CLK);
    ARR_IN = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge CLK);
      if (BUSY) seen = 1'b1;
    end
    ARR_IN = 1'b0;
    checks++; if (!seen) begin failures++; $display("FAIL mid_issue_busy: got 0 want 1 within 60 cycles"); end
    MR = 1'b1;
    #1;
    checks++; if ({UP, DOWN, REJ, ERR, BUSY} !== 5'b0 || WT !== '0) begin
      failures++; $display("FAIL mid_issue_async_clear: got %05b wt=%0d want 00000 wt=0", {UP, DOWN, REJ, ERR, BUSY}, WT);
    end
    repeat (2) @(negedge CLK);
    MR = 1'b0;
    u0 = up_cnt;
    repeat (50) @(negedge CLK);
    checks++; if (up_cnt - u0 != 0) begin failures++; $display("FAIL mid_issue_no_up: got %0d want 0", up_cnt - u0); end
    $display("reset_mid_issue: up_after_release=%0d", up_cnt - u0);
  endtask

  task automatic test_single_arrival;
    int u0, b0, r0;
    load_co(3'd0);
    u0 = up_cnt; b0 = busy_cnt; r0 = rej_cnt;
    pulse(1'b0, 20, 40);
    checks++; if (up_cnt - u0 != 1) begin failures++; $display("FAIL single_up: got %0d want 1", up_cnt - u0); end
    checks++; if (busy_cnt - b0 != 1 + SETTLE) begin failures++; $display("FAIL single_busy: got %0d want %0d", busy_cnt - b0, 1 + SETTLE); end
    checks++; if (rej_cnt - r0 != 0) begin failures++; $display("FAIL single_rej: got %0d want 0", rej_cnt - r0); end
    checks++; if (WT !== WT_W'(SVC_TIME)) begin failures++; $display("FAIL single_wt: got %0d want %0d", WT, SVC_TIME); end
    $display("single_arrival: ups=%0d busy=%0d wt=%0d", up_cnt - u0, busy_cnt - b0, WT);
  endtask

  task automatic test_glitch;
    int ev0, len;
    ev0 = up_cnt + dn_cnt + rej_cnt + err_cnt;
    pulse(1'b0, 10, 30);
    checks++; if (up_cnt + dn_cnt + rej_cnt + err_cnt != ev0) begin
      failures++; $display("FAIL glitch_10: got %0d events want 0", up_cnt + dn_cnt + rej_cnt + err_cnt - ev0);
    end
    for (int i = 0; i < 4; i++) begin
      len = $urandom_range(1, DEB_CYC - 2);
      pulse(1'($urandom_range(0, 1)), len, 25);
    end
    checks++; if (up_cnt + dn_cnt + rej_cnt + err_cnt != ev0) begin
      failures++; $display("FAIL glitch_random: got %0d events want 0", up_cnt + dn_cnt + rej_cnt + err_cnt - ev0);
    end
    $display("glitch: events=%0d", up_cnt + dn_cnt + rej_cnt + err_cnt - ev0);
  endtask

  task automatic test_simultaneous;
    int u0, d0;
    load_co(3'd3);
    u0 = up_cnt; d0 = dn_cnt;
    @(negedge CLK);
    ARR_IN = 1'b1;
    SRV_IN = 1'b1;
    repeat (20) @(negedge CLK);
    ARR_IN = 1'b0;
    SRV_IN = 1'b0;
    repeat (40) @(negedge CLK);
    checks++; if (up_cnt - u0 != 1 || dn_cnt - d0 != 1) begin
      failures++; $display("FAIL simul_counts: got up=%0d dn=%0d want 1 1", up_cnt - u0, dn_cnt - d0);
    end
    checks++; if (last_up - last_dn < SETTLE + 1) begin
      failures++; $display("FAIL simul_order_gap: got up-dn=%0d want >=%0d", last_up - last_dn, SETTLE + 1);
    end
    checks++; if (CO !== 3'd3 || WT !== WT_W'(3 * SVC_TIME)) begin
      failures++; $display("FAIL simul_co_wt: got co=%0d wt=%0d want 3 %0d", CO, WT, 3 * SVC_TIME);
    end
    $display("simultaneous: dn@%0d up@%0d", last_dn, last_up);
  endtask

  task automatic test_full_empty;
    int u0, r0, d0, e0;
    load_co(3'd7);
    u0 = up_cnt; r0 = rej_cnt;
    pulse(1'b0, 20, 40);
    checks++; if (rej_cnt - r0 != 1 || up_cnt - u0 != 0) begin
      failures++; $display("FAIL full_rej: got rej=%0d up=%0d want 1 0", rej_cnt - r0, up_cnt - u0);
    end
    checks++; if (WT !== WT_W'(7 * SVC_TIME)) begin failures++; $display("FAIL full_wt: got %0d want %0d", WT, 7 * SVC_TIME); end
    load_co(3'd0);
    d0 = dn_cnt; e0 = err_cnt;
    pulse(1'b1, 20, 40);
    checks++; if (err_cnt - e0 != 1 || dn_cnt - d0 != 0) begin
      failures++; $display("FAIL empty_err: got err=%0d dn=%0d want 1 0", err_cnt - e0, dn_cnt - d0);
    end
    checks++; if (WT !== '0) begin failures++; $display("FAIL empty_wt: got %0d want 0", WT); end
    $display("full_empty: rej=%0d err=%0d", rej_cnt - r0, err_cnt - e0);
  endtask

  task automatic test_back_to_back;
    int u0;
    load_co(3'd0);
    u0 = up_cnt;
    for (int i = 0; i < 5; i++) pulse(1'b0, DEB_CYC + 4, DEB_CYC + 4);
    repeat (20) @(negedge CLK);
    checks++; if (up_cnt - u0 != 5) begin failures++; $display("FAIL b2b_ups: got %0d want 5", up_cnt - u0); end
    checks++; if (CO !== 3'd5) begin failures++; $display("FAIL b2b_co: got %0d want 5", CO); end
    checks++; if (WT !== WT_W'(5 * SVC_TIME)) begin failures++; $display("FAIL b2b_wt: got %0d want %0d", WT, 5 * SVC_TIME); end
    $display("back_to_back: ups=%0d co=%0d wt=%0d", up_cnt - u0, CO, WT);
  endtask

  task automatic test_random;
    int n, eu, ed, er, ee, u0, d0, r0, e0, hi;
    bit is_srv;
    n = $urandom_range(0, 7);
    load_co(3'(n));
    eu = 0; ed = 0; er = 0; ee = 0;
    u0 = up_cnt; d0 = dn_cnt; r0 = rej_cnt; e0 = err_cnt;
    for (int i = 0; i < 14; i++) begin
      is_srv = 1'($urandom_range(0, 1));
      hi = $urandom_range(DEB_CYC + 3, DEB_CYC + 10);
      if ($urandom_range(0, 3) == 0) pulse(~is_srv, $urandom_range(1, DEB_CYC - 4), 10);
      pulse(is_srv, hi, 30);
      if (is_srv) begin
        if (n == 0) ee++; else begin n--; ed++; end
      end else begin
        if (n == 7) er++; else begin n++; eu++; end
      end
      $display("random[%0d]: %s hi=%0d queue=%0d", i, is_srv ? "srv" : "arr", hi, n);
    end
    checks++; if (up_cnt - u0 != eu || dn_cnt - d0 != ed) begin
      failures++; $display("FAIL random_updn: got up=%0d dn=%0d want %0d %0d", up_cnt - u0, dn_cnt - d0, eu, ed);
    end
    checks++; if (rej_cnt - r0 != er || err_cnt - e0 != ee) begin
      failures++; $display("FAIL random_rej_err: got rej=%0d err=%0d want %0d %0d", rej_cnt - r0, err_cnt - e0, er, ee);
    end
    checks++; if (CO !== 3'(n) || WT !== WT_W'(n * SVC_TIME)) begin
      failures++; $display("FAIL random_co_wt: got co=%0d wt=%0d want %0d %0d", CO, WT, n, n * SVC_TIME);
    end
  endtask

  task automatic test_invariants;
    checks++; if (both_viol != 0) begin failures++; $display("FAIL up_down_overlap: got %0d want 0", both_viol); end
    checks++; if (sep_viol != 0) begin failures++; $display("FAIL pulse_separation: got %0d want 0", sep_viol); end
    $display("invariants: overlap=%0d separation=%0d", both_viol, sep_viol);
  endtask

  initial begin
    test_reset;
    test_reset_mid_issue;
    test_single_arrival;
    test_glitch;
    test_simultaneous;
    test_full_empty;
    test_back_to_back;
    test_random;
    test_invariants;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
